// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stall, taken-branch squash, multi-cycle MUL hold.
// Outputs are combinational from state and inputs; the FSM and the saturating perf counters are registered.
module pipeline_hazard_ctrl #(
   parameter int MUL_LAT = 3,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic             enable,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs2,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_rd,
   input  logic             ex_is_mul,
   input  logic             mem_branch_taken,
   output logic             pc_en,
   output logic             pc_sel_branch,
   output logic             if_id_en,
   output logic             if_id_flush,
   output logic             id_ex_en,
   output logic             id_ex_bubble,
   output logic             ex_mem_en,
   output logic             ex_mem_bubble,
   output logic             mem_wb_en,
   output logic             mul_start,
   output logic             mul_busy,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic {ST_RUN = 1'b0, ST_MUL = 1'b1} state_t;

   // The start cycle and the release cycle are not spent in the countdown.
   localparam logic [3:0] CNT_LOAD = 4'(MUL_LAT - 2);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [3:0]       r_cnt;
   logic [3:0]       w_cnt_nxt;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;
   logic             w_loaduse;
   logic             w_stall_inc;
   logic             w_flush_inc;

   assign w_loaduse = ex_mem_read && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

   always_comb begin
      pc_en         = 1'b0;
      pc_sel_branch = 1'b0;
      if_id_en      = 1'b0;
      if_id_flush   = 1'b0;
      id_ex_en      = 1'b0;
      id_ex_bubble  = 1'b0;
      ex_mem_en     = 1'b0;
      ex_mem_bubble = 1'b0;
      mem_wb_en     = 1'b0;
      mul_start     = 1'b0;
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_flush_inc   = 1'b0;
      w_stall_inc   = 1'b0;
      if (arst_n && enable) begin
         case (r_state)
            ST_RUN: begin
               pc_en     = 1'b1;
               if_id_en  = 1'b1;
               id_ex_en  = 1'b1;
               ex_mem_en = 1'b1;
               mem_wb_en = 1'b1;
               if (mem_branch_taken) begin
                  pc_sel_branch = 1'b1;
                  if_id_flush   = 1'b1;
                  id_ex_bubble  = 1'b1;
                  ex_mem_bubble = 1'b1;
                  w_flush_inc   = 1'b1;
               end else if (ex_is_mul) begin
                  mul_start     = 1'b1;
                  pc_en         = 1'b0;
                  if_id_en      = 1'b0;
                  id_ex_en      = 1'b0;
                  ex_mem_bubble = 1'b1;
                  w_state_nxt   = ST_MUL;
                  w_cnt_nxt     = CNT_LOAD;
               end else if (w_loaduse) begin
                  pc_en        = 1'b0;
                  if_id_en     = 1'b0;
                  id_ex_bubble = 1'b1;
               end
            end
            ST_MUL: begin
               // MEM only ever sees bubbles here, so a branch flag is ignored.
               ex_mem_en = 1'b1;
               mem_wb_en = 1'b1;
               if (r_cnt != 4'd0) begin
                  ex_mem_bubble = 1'b1;
                  w_cnt_nxt     = r_cnt - 4'd1;
               end else begin
                  pc_en       = 1'b1;
                  if_id_en    = 1'b1;
                  id_ex_en    = 1'b1;
                  w_state_nxt = ST_RUN;
               end
            end
            default: w_state_nxt = ST_RUN;
         endcase
         w_stall_inc = !pc_en;
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_state     <= ST_RUN;
         r_cnt       <= 4'd0;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_stall_inc && (r_stall_cnt != {CNT_W{1'b1}}))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (w_flush_inc && (r_flush_cnt != {CNT_W{1'b1}}))
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
   end

   assign mul_busy  = arst_n && (r_state == ST_MUL);
   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: vector table, hand sequences for multi-cycle cases, randomized run vs model.
module tb_pipeline_hazard_ctrl;

   localparam int MUL_LAT = 3;
   localparam int CNT_W   = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   // {pc_en, pc_sel_branch, if_id_en, if_id_flush, id_ex_en, id_ex_bubble,
   //  ex_mem_en, ex_mem_bubble, mem_wb_en, mul_start, mul_busy}
   localparam logic [10:0] O_OFF  = 11'b00000000000;
   localparam logic [10:0] O_OFFB = 11'b00000000001;
   localparam logic [10:0] O_RUN  = 11'b10101010100;
   localparam logic [10:0] O_BR   = 11'b11111111100;
   localparam logic [10:0] O_LU   = 11'b00001110100;
   localparam logic [10:0] O_MS   = 11'b00000011110;
   localparam logic [10:0] O_MW   = 11'b00000011101;
   localparam logic [10:0] O_MR   = 11'b10101010101;

   logic clk = 1'b0;
   logic arst_n = 1'b0;
   logic enable = 1'b0;
   logic [4:0] id_rs1 = 5'd0;
   logic [4:0] id_rs2 = 5'd0;
   logic id_uses_rs2 = 1'b0;
   logic ex_mem_read = 1'b0;
   logic [4:0] ex_rd = 5'd0;
   logic ex_is_mul = 1'b0;
   logic mem_branch_taken = 1'b0;
   logic pc_en, pc_sel_branch, if_id_en, if_id_flush, id_ex_en, id_ex_bubble;
   logic ex_mem_en, ex_mem_bubble, mem_wb_en, mul_start, mul_busy;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;
   logic [10:0] act_o;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
      .clk(clk), .arst_n(arst_n), .enable(enable),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
      .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_is_mul(ex_is_mul),
      .mem_branch_taken(mem_branch_taken),
      .pc_en(pc_en), .pc_sel_branch(pc_sel_branch), .if_id_en(if_id_en),
      .if_id_flush(if_id_flush), .id_ex_en(id_ex_en), .id_ex_bubble(id_ex_bubble),
      .ex_mem_en(ex_mem_en), .ex_mem_bubble(ex_mem_bubble), .mem_wb_en(mem_wb_en),
      .mul_start(mul_start), .mul_busy(mul_busy),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   assign act_o = {pc_en, pc_sel_branch, if_id_en, if_id_flush, id_ex_en, id_ex_bubble,
                   ex_mem_en, ex_mem_bubble, mem_wb_en, mul_start, mul_busy};

   typedef struct {
      logic        en, br, mul, mr, u2;
      logic [4:0]  rd, rs1, rs2;
      logic [10:0] exp;
   } vec_t;

   vec_t tbl[12];
   int n_chk = 0;
   int n_pass = 0;

   // Reference model: multiply progress as "MUL-state cycles still to come".
   int m_left = 0;
   int m_stall = 0;
   int m_flush = 0;

   function automatic vec_t mk(input logic en, br, mul, mr, u2,
                               input logic [4:0] rd, rs1, rs2, input logic [10:0] exp);
      vec_t v;
      v.en = en; v.br = br; v.mul = mul; v.mr = mr; v.u2 = u2;
      v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.exp = exp;
      return v;
   endfunction

   function automatic logic [10:0] ref_out(input logic en, br, mul, lu);
      if (!en) return (m_left > 0) ? O_OFFB : O_OFF;
      if (m_left > 1) return O_MW;
      if (m_left == 1) return O_MR;
      if (br) return O_BR;
      if (mul) return O_MS;
      if (lu) return O_LU;
      return O_RUN;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic drive(input logic en, br, mul, mr, u2, input logic [4:0] rd, rs1, rs2);
      enable = en; mem_branch_taken = br; ex_is_mul = mul; ex_mem_read = mr;
      id_uses_rs2 = u2; ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
   endtask

   task automatic cyc(input string name, input logic [10:0] exp);
      @(negedge clk);
      chk(name, 32'(act_o), 32'(exp));
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      arst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
      @(posedge clk);
      #1;
      arst_n = 1'b1;
   endtask

   initial begin
      logic [10:0] exp;
      logic r_en, r_br, r_mul, r_mr, r_u2, lu;
      logic [4:0] r_rd, r_rs1, r_rs2;

      tbl[0]  = mk(1, 0, 0, 0, 0, 5'd0, 5'd1, 5'd2, O_RUN);
      tbl[1]  = mk(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, O_BR);
      tbl[2]  = mk(1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, O_BR);
      tbl[3]  = mk(1, 1, 0, 1, 0, 5'd7, 5'd7, 5'd0, O_BR);
      tbl[4]  = mk(1, 0, 0, 1, 0, 5'd9, 5'd9, 5'd3, O_LU);
      tbl[5]  = mk(1, 0, 0, 1, 1, 5'd9, 5'd4, 5'd9, O_LU);
      tbl[6]  = mk(1, 0, 0, 1, 0, 5'd9, 5'd4, 5'd9, O_RUN);
      tbl[7]  = mk(1, 0, 0, 1, 1, 5'd0, 5'd0, 5'd0, O_RUN);
      tbl[8]  = mk(1, 0, 0, 0, 1, 5'd9, 5'd9, 5'd9, O_RUN);
      tbl[9]  = mk(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, O_OFF);
      tbl[10] = mk(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, O_OFF);
      tbl[11] = mk(0, 0, 0, 1, 1, 5'd9, 5'd9, 5'd9, O_OFF);

      // Outputs stay at 0 under reset even with every event requested.
      drive(1, 1, 1, 1, 1, 5'd3, 5'd3, 5'd3);
      #2;
      chk("reset_out", 32'(act_o), 32'(O_OFF));
      chk("reset_stall", 32'(stall_cnt), 32'd0);
      chk("reset_flush", 32'(flush_cnt), 32'd0);
      do_reset();

      for (int i = 0; i < 12; i++) begin
         drive(tbl[i].en, tbl[i].br, tbl[i].mul, tbl[i].mr, tbl[i].u2,
               tbl[i].rd, tbl[i].rs1, tbl[i].rs2);
         cyc($sformatf("tbl%0d", i), tbl[i].exp);
      end
      chk("tbl_stall_cnt", 32'(stall_cnt), 32'd2);
      chk("tbl_flush_cnt", 32'(flush_cnt), 32'd3);

      // lw x5 ; add x6,x5,x2
      do_reset();
      drive(1, 0, 0, 1, 1, 5'd5, 5'd5, 5'd2);
      cyc("lu_stall", O_LU);
      drive(1, 0, 0, 0, 1, 5'd6, 5'd5, 5'd2);
      cyc("lu_resume", O_RUN);
      chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);

      // lw x0 ; add x6,x0,x0
      do_reset();
      drive(1, 0, 0, 1, 1, 5'd0, 5'd0, 5'd0);
      cyc("x0_nostall", O_RUN);
      chk("x0_stall_cnt", 32'(stall_cnt), 32'd0);

      // mul occupies EX for MUL_LAT cycles
      do_reset();
      drive(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
      cyc("mul_start", O_MS);
      cyc("mul_wait", O_MW);
      cyc("mul_release", O_MR);
      drive(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
      cyc("mul_after", O_RUN);
      chk("mul_stall_cnt", 32'(stall_cnt), 32'd2);

      // taken branch in MEM
      do_reset();
      drive(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
      cyc("br_flush", O_BR);
      drive(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
      cyc("br_after", O_RUN);
      chk("br_flush_cnt", 32'(flush_cnt), 32'd1);
      chk("br_stall_cnt", 32'(stall_cnt), 32'd0);

      // taken branch kills a mul in EX
      do_reset();
      drive(1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0);
      cyc("brmul_flush", O_BR);
      drive(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
      cyc("brmul_run", O_RUN);

      // enable dropped for 4 cycles with one countdown step left
      do_reset();
      drive(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
      cyc("frz_start", O_MS);
      enable = 1'b0;
      for (int i = 0; i < 4; i++) cyc($sformatf("frz_hold%0d", i), O_OFFB);
      enable = 1'b1;
      cyc("frz_wait", O_MW);
      cyc("frz_release", O_MR);
      drive(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
      cyc("frz_after", O_RUN);
      chk("frz_stall_cnt", 32'(stall_cnt), 32'd2);

      // reset pulsed mid-MUL
      do_reset();
      drive(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
      cyc("rst_mul_start", O_MS);
      @(negedge clk);
      chk("rst_mul_wait", 32'(act_o), 32'(O_MW));
      arst_n = 1'b0;
      #1;
      chk("rst_mid_out", 32'(act_o), 32'(O_OFF));
      chk("rst_mid_stall", 32'(stall_cnt), 32'd0);
      drive(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
      @(posedge clk);
      #1;
      arst_n = 1'b1;
      cyc("rst_mid_run", O_RUN);

      // counter saturation
      do_reset();
      drive(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
      for (int i = 0; i < CNT_MAX + 5; i++) begin
         @(posedge clk);
         #1;
      end
      chk("sat_flush", 32'(flush_cnt), 32'(CNT_MAX));
      drive(1, 0, 0, 1, 0, 5'd4, 5'd4, 5'd0);
      for (int i = 0; i < CNT_MAX + 5; i++) begin
         @(posedge clk);
         #1;
      end
      chk("sat_stall", 32'(stall_cnt), 32'(CNT_MAX));
      chk("sat_flush_hold", 32'(flush_cnt), 32'(CNT_MAX));

      // randomized run against the model
      do_reset();
      m_left = 0; m_stall = 0; m_flush = 0;
      for (int i = 0; i < 400; i++) begin
         if (i % 64 == 63) begin
            arst_n = 1'b0;
            #1;
            chk("rnd_rst_out", 32'(act_o), 32'(O_OFF));
            chk("rnd_rst_stall", 32'(stall_cnt), 32'd0);
            arst_n = 1'b1;
            m_left = 0; m_stall = 0; m_flush = 0;
         end
         r_en  = ($urandom_range(7) != 0);
         r_br  = ($urandom_range(7) == 0);
         r_mul = ($urandom_range(5) == 0);
         r_mr  = ($urandom_range(1) == 1);
         r_u2  = ($urandom_range(1) == 1);
         r_rd  = 5'($urandom_range(3));
         r_rs1 = 5'($urandom_range(3));
         r_rs2 = 5'($urandom_range(3));
         drive(r_en, r_br, r_mul, r_mr, r_u2, r_rd, r_rs1, r_rs2);
         lu  = r_mr && (r_rd != 0) && ((r_rd == r_rs1) || (r_u2 && (r_rd == r_rs2)));
         exp = ref_out(r_en, r_br, r_mul, lu);
         @(negedge clk);
         chk("rnd_out", 32'(act_o), 32'(exp));
         chk("rnd_stall", 32'(stall_cnt), 32'(m_stall));
         chk("rnd_flush", 32'(flush_cnt), 32'(m_flush));
         @(posedge clk);
         if (r_en) begin
            if (!exp[10] && m_stall < CNT_MAX) m_stall++;
            if (m_left == 0 && r_br && m_flush < CNT_MAX) m_flush++;
            if (m_left > 0) m_left--;
            else if (!r_br && r_mul) m_left = MUL_LAT - 1;
         end
         #1;
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
